okwire_alu_bank: RTL and testbench
==================================

// Module: okwire_alu_bank
// PURPOSE
//  Parametrised, multi-channel successor to the single wire-in adder feeding a wire-out.
//  - NCH operand pairs arrive on okWireIn endpoints; results and carries return on okWireOut endpoints.
//  - A 1-cycle okTriggerIn pulse snapshots all operands and the mode.
//  - One shared lane then processes one channel per cycle; completion is reported by busy/done.
//  - Also drives the open-drain LED bank (active-low, z when off).
// PARAMETERS
//  W    32  operand/result width per channel (>=8)
//  NCH  4   channel count (>=1); index counter width = max(1,$clog2(NCH))
// PORTS
//  ti_clk       in   1        host interface clock; sole clock
//  rst_n        in   1        asynchronous, active-low reset
//  trig_update  in   1        1-cycle start pulse (okTriggerIn bit)
//  mode         in   2        0 ADD, 1 SUB (a-b), 2 AND, 3 XOR
//  ep_a         in   NCH*W    operand A, channel k at [k*W +: W]
//  ep_b         in   NCH*W    operand B, channel k at [k*W +: W]
//  ep_led       in   8        LED request, bit=1 lights LED
//  result       out  NCH*W    registered per-channel result
//  carry        out  NCH      ADD carry-out / SUB borrow; 0 for AND/XOR
//  busy         out  1        high while channels are being computed
//  done         out  1        1-cycle pulse after the last channel is written
//  missed       out  1        sticky: trigger arrived while not IDLE
//  led          out  8        led[i] = ep_led[i] ? 1'b0 : 1'bz (combinational)
// BEHAVIOUR
//  - Reset: state IDLE, idx 0, snapshots/result/carry 0, busy/done/missed 0.
//    led follows ep_led even during reset.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, trig_update=1 at edge T:
//    - snapshot ep_a/ep_b/mode, idx<=0, enter RUN; busy=1 from T+1.
//    - missed<=0 (cleared by every accepted trigger).
//  - RUN, each edge:
//    - result[idx]/carry[idx] <= lane(snapA[idx], snapB[idx], snapMode); idx++.
//    - After idx==NCH-1: enter DONE.
//    - Channel k is valid at T+1+k.
//  - DONE (one cycle): busy=0, done=1; then IDLE. Total trigger->done latency NCH+1 cycles.
//  - trig_update in RUN or DONE: ignored, missed<=1.
//    - Snapshots are unaffected; ep_* changes during RUN have no effect.
//  - Arithmetic: W-bit modular.
//    - ADD carry = bit W of a+b.
//    - SUB carry = (a<b) unsigned borrow.
//  - Channels not yet recomputed keep their previous values; result is never cleared except by reset.
//  - rst_n low mid-RUN: immediate abort to reset values; partial results are discarded (zeroed).
// CONFIGURATION
//  - OKWIRE_ALU_SAT_EN defined: unsigned saturation.
//    - ADD with carry -> all ones.
//    - SUB with borrow -> 0.
//    - carry still reports the raw carry/borrow.
//  - Undefined: results wrap modulo 2^W.
// STRUCTURE
//  - Package okwire_alu_pkg: mode enum constants (MODE_ADD=2'd0, MODE_SUB, MODE_AND, MODE_XOR) and FSM state encoding.
//  - Sub-module okwire_alu_lane: purely combinational (a,b,mode) -> (y,c).
//    - Contains the SAT_EN logic.
//    - Instantiated once and time-shared over channels.
//  - Top holds the FSM, snapshots, index counter and LED function.
// TESTING (W=32, NCH=4)
//  - Reset values: rst_n low with ep_led=8'h05 -> result=0, busy=0, led=8'bzzzzz0z0.
//  - ADD: a={4,3,2,FFFFFFFF}, b={1,1,1,1}, mode 0, pulse at T.
//    - busy T+1..T+4, done at T+5.
//    - result={5,4,3,0}, carry=4'b0001.
//  - SUB: a0=3, b0=5.
//    - Without SAT_EN: result0=FFFFFFFE, carry0=1.
//    - With OKWIRE_ALU_SAT_EN: result0=0, carry0=1.
//  - AND/XOR: a=F0F0F0F0, b=FF00FF00.
//    - AND -> F000F000, XOR -> 0FF00FF0, carry=0.
//  - Trigger at T+2 during RUN: missed=1, results match the first snapshot.
//    - The next accepted trigger clears missed.
//  - rst_n low at T+2: results return to 0, busy=0, no done pulse.
//    - A fresh trigger then completes normally.

Source files
------------

// File: rtl/okwire_alu_pkg.sv
// Shared types for the okWire ALU bank: operation modes, FSM states, index sizing.
package okwire_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_AND = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/okwire_alu_lane.sv
// Combinational ALU lane (a, b, mode) -> (y, c), time-shared across channels.
// OKWIRE_ALU_SAT_EN selects unsigned saturation of ADD/SUB results.
module okwire_alu_lane
    import okwire_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  mode_e        mode_i,
    output logic [W-1:0] y_o,
    output logic         c_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        diff = {1'b0, a_i} - {1'b0, b_i};
        y_o  = '0;
        c_o  = 1'b0;
        case (mode_i)
            MODE_ADD: begin
                y_o = sum[W-1:0];
                c_o = sum[W];
`ifdef OKWIRE_ALU_SAT_EN
                if (sum[W]) y_o = '1;
`endif
            end
            MODE_SUB: begin
                // Bit W of the widened difference is the unsigned borrow (a < b).
                y_o = diff[W-1:0];
                c_o = diff[W];
`ifdef OKWIRE_ALU_SAT_EN
                if (diff[W]) y_o = '0;
`endif
            end
            MODE_AND: y_o = a_i & b_i;
            MODE_XOR: y_o = a_i ^ b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/okwire_alu_bank.sv
// Multi-channel okWire ALU bank: trigger snapshots operands, one shared lane
// computes one channel per cycle. Optional saturation via OKWIRE_ALU_SAT_EN.
module okwire_alu_bank
    import okwire_alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int NCH = 4
) (
    input  logic             ti_clk,
    input  logic             rst_n,
    input  logic             trig_update,
    input  logic [1:0]       mode,
    input  logic [NCH*W-1:0] ep_a,
    input  logic [NCH*W-1:0] ep_b,
    input  logic [7:0]       ep_led,
    output logic [NCH*W-1:0] result,
    output logic [NCH-1:0]   carry,
    output logic             busy,
    output logic             done,
    output logic             missed,
    output logic [7:0]       led
);

    localparam int IW = idx_width(NCH);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           missed_q, missed_d;
    logic           snap_en;
    logic           wr_en;

    mode_e          mode_q;
    logic [W-1:0]   snap_a_q [NCH];
    logic [W-1:0]   snap_b_q [NCH];
    logic [W-1:0]   result_q [NCH];
    logic [NCH-1:0] carry_q;

    logic [W-1:0]   lane_y;
    logic           lane_c;

    okwire_alu_lane #(.W(W)) u_lane (
        .a_i    (snap_a_q[idx_q]),
        .b_i    (snap_b_q[idx_q]),
        .mode_i (mode_q),
        .y_o    (lane_y),
        .c_o    (lane_c)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        missed_d = missed_q;
        snap_en  = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_update) begin
                    snap_en  = 1'b1;
                    idx_d    = '0;
                    missed_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = 1'b1;
                if (trig_update) missed_d = 1'b1;
                if (idx_q == IW'(NCH - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (trig_update) missed_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            missed_q <= missed_d;
        end
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_ADD;
            carry_q <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                snap_a_q[k] <= '0;
                snap_b_q[k] <= '0;
                result_q[k] <= '0;
            end
        end else begin
            if (snap_en) begin
                mode_q <= mode_e'(mode);
                for (int unsigned k = 0; k < NCH; k++) begin
                    snap_a_q[k] <= ep_a[k*W +: W];
                    snap_b_q[k] <= ep_b[k*W +: W];
                end
            end
            if (wr_en) begin
                result_q[idx_q] <= lane_y;
                carry_q[idx_q]  <= lane_c;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_result
        assign result[k*W +: W] = result_q[k];
    end

    // Open-drain LED bank: pull low to light, release otherwise.
    for (genvar i = 0; i < 8; i++) begin : g_led
        assign led[i] = ep_led[i] ? 1'b0 : 1'bz;
    end

    assign carry  = carry_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign missed = missed_q;

endmodule

// File: tb/tb_okwire_alu_bank.sv
// Directed table-driven bench for okwire_alu_bank (W=32, NCH=4).
module tb_okwire_alu_bank;

    localparam int W   = 32;
    localparam int NCH = 4;
    localparam int NV  = 5;

    logic             ti_clk;
    logic             rst_n;
    logic             trig_update;
    logic [1:0]       mode;
    logic [NCH*W-1:0] ep_a;
    logic [NCH*W-1:0] ep_b;
    logic [7:0]       ep_led;
    logic [NCH*W-1:0] result;
    logic [NCH-1:0]   carry;
    logic             busy;
    logic             done;
    logic             missed;
    wire  [7:0]       led;

    okwire_alu_bank #(.W(W), .NCH(NCH)) dut (
        .ti_clk      (ti_clk),
        .rst_n       (rst_n),
        .trig_update (trig_update),
        .mode        (mode),
        .ep_a        (ep_a),
        .ep_b        (ep_b),
        .ep_led      (ep_led),
        .result      (result),
        .carry       (carry),
        .busy        (busy),
        .done        (done),
        .missed      (missed),
        .led         (led)
    );

    initial ti_clk = 1'b0;
    always #5 ti_clk = ~ti_clk;

    typedef struct {
        logic [NCH*W-1:0] a;
        logic [NCH*W-1:0] b;
        logic [1:0]       m;
        logic [NCH*W-1:0] r;
        logic [NCH-1:0]   c;
    } vec_t;

    vec_t             vec [NV];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [NCH*W-1:0] prev_r;
    logic [NCH-1:0]   prev_c;

    task automatic chk(input string name, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Applies one vector; optionally fires a second trigger mid-run with different operands.
    task automatic run_vec(input int v, input bit inject);
        logic [NCH*W-1:0] er;
        logic [NCH-1:0]   ec;
        @(negedge ti_clk);
        ep_a = vec[v].a;
        ep_b = vec[v].b;
        mode = vec[v].m;
        trig_update = 1'b1;
        @(posedge ti_clk);
        @(negedge ti_clk);
        trig_update = 1'b0;
        for (int s = 1; s <= NCH + 1; s++) begin
            if (s > 1) @(negedge ti_clk);
            if (inject && s == 3) trig_update = 1'b0;
            er = prev_r;
            ec = prev_c;
            for (int k = 0; k < NCH; k++) begin
                if (k <= s - 2) begin
                    er[k*W +: W] = vec[v].r[k*W +: W];
                    ec[k]        = vec[v].c[k];
                end
            end
            chk($sformatf("busy v%0d s%0d", v, s), {127'd0, busy}, {127'd0, (s <= NCH)});
            chk($sformatf("done v%0d s%0d", v, s), {127'd0, done}, {127'd0, (s == NCH + 1)});
            chk($sformatf("result v%0d s%0d", v, s), result, er);
            chk($sformatf("carry v%0d s%0d", v, s), {124'd0, carry}, {124'd0, ec});
            if (s == 1) chk($sformatf("missed_clr v%0d", v), {127'd0, missed}, 128'd0);
            if (inject && s == 2) begin
                trig_update = 1'b1;
                ep_a = '0;
                ep_b = '0;
                mode = 2'd3;
            end
            if (inject && s == 3) chk($sformatf("missed_set v%0d", v), {127'd0, missed}, 128'd1);
        end
        @(negedge ti_clk);
        chk($sformatf("idle v%0d", v), {126'd0, busy, done}, 128'd0);
        chk($sformatf("missed_end v%0d", v), {127'd0, missed}, {127'd0, inject});
        prev_r = vec[v].r;
        prev_c = vec[v].c;
    endtask

    initial begin
        int done_seen;

        vec[0] = '{a: {32'h4, 32'h3, 32'h2, 32'hFFFFFFFF}, b: {4{32'h1}}, m: 2'd0,
                   r: {32'h5, 32'h4, 32'h3, 32'h0}, c: 4'b0001};
`ifdef OKWIRE_ALU_SAT_EN
        vec[1] = '{a: {32'h5, 32'h0, 32'hA, 32'h3}, b: {32'h5, 32'h1, 32'h3, 32'h5}, m: 2'd1,
                   r: {32'h0, 32'h0, 32'h7, 32'h0}, c: 4'b0101};
        vec[4] = '{a: {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h80000000},
                   b: {32'hFFFFFFFF, 32'h1, 32'h0, 32'h80000000}, m: 2'd0,
                   r: {32'hFFFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF}, c: 4'b1001};
`else
        vec[1] = '{a: {32'h5, 32'h0, 32'hA, 32'h3}, b: {32'h5, 32'h1, 32'h3, 32'h5}, m: 2'd1,
                   r: {32'h0, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFFE}, c: 4'b0101};
        vec[4] = '{a: {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h80000000},
                   b: {32'hFFFFFFFF, 32'h1, 32'h0, 32'h80000000}, m: 2'd0,
                   r: {32'hFFFFFFFE, 32'h80000000, 32'h0, 32'h0}, c: 4'b1001};
`endif
        vec[2] = '{a: {4{32'hF0F0F0F0}}, b: {4{32'hFF00FF00}}, m: 2'd2,
                   r: {4{32'hF000F000}}, c: 4'b0000};
        vec[3] = '{a: {4{32'hF0F0F0F0}}, b: {4{32'hFF00FF00}}, m: 2'd3,
                   r: {4{32'h0FF00FF0}}, c: 4'b0000};

        rst_n = 1'b0;
        trig_update = 1'b0;
        mode = 2'd0;
        ep_a = '0;
        ep_b = '0;
        ep_led = 8'h05;
        prev_r = '0;
        prev_c = '0;
        repeat (2) @(negedge ti_clk);
        chk("rst_result", result, '0);
        chk("rst_carry", {124'd0, carry}, '0);
        chk("rst_flags", {125'd0, busy, done, missed}, '0);
        for (int i = 0; i < 8; i++)
            if (ep_led[i]) chk($sformatf("led%0d_on_rst", i), {127'd0, led[i]}, '0);
        rst_n = 1'b1;
        ep_led = 8'hA0;
        @(negedge ti_clk);
        for (int i = 0; i < 8; i++)
            if (ep_led[i]) chk($sformatf("led%0d_on", i), {127'd0, led[i]}, '0);

        for (int v = 0; v < NV; v++) run_vec(v, 1'b0);

        run_vec(0, 1'b1);
        run_vec(2, 1'b0);

        // Reset mid-run: abort after channels 0 and 1 have been written.
        @(negedge ti_clk);
        ep_a = vec[4].a;
        ep_b = vec[4].b;
        mode = vec[4].m;
        trig_update = 1'b1;
        @(posedge ti_clk);
        @(negedge ti_clk);
        trig_update = 1'b0;
        repeat (2) @(negedge ti_clk);
        chk("abort_pre_busy", {127'd0, busy}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", result, '0);
        chk("abort_carry", {124'd0, carry}, '0);
        chk("abort_busy", {127'd0, busy}, '0);
        done_seen = 0;
        @(negedge ti_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ti_clk);
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", 128'(done_seen), '0);
        prev_r = '0;
        prev_c = '0;
        run_vec(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
